fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one asynchronous FIFO write port among NUM_REQ producers in the write clock domain. Each producer offers a burst over a valid/ready handshake. The arbiter grants one producer at a time, muxes its data onto the FIFO write port and throttles it with the FIFO `full` flag. It sits directly in front of the FIFO write side (`wen`, `data_in`, `full`) and owns all write-side sequencing.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter and its round-robin
// picker: the arbiter state type, default parameter values and a width
// helper used to size the grant index and the burst/idle counters.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_MAX_BURST    = 4;
  localparam int unsigned DEF_IDLE_TIMEOUT = 8;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// rr_picker
// Purely combinational round-robin selector. Scans the request vector
// starting one position after last_grant (wrapping modulo NUM_REQ) and
// returns the first asserted index.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently
//   any_req    : at least one request bit is set
//   pick       : chosen index (meaningful only when any_req is high)
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       any_req,
  output logic [$clog2(NUM_REQ)-1:0] pick
);

  localparam int unsigned IW = bits_for(NUM_REQ);

  assign any_req = |req;

  always_comb begin
    logic             found;
    logic [IW-1:0]    idx;
    found = 1'b0;
    idx   = '0;
    pick  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IW'((32'(last_grant) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing one asynchronous-FIFO write port among
// NUM_REQ producers in the write clock domain. A granted producer may
// write up to MAX_BURST beats; the grant ends on its last beat, on the
// beat limit, or after IDLE_TIMEOUT consecutive cycles with valid low.
// Every burst end is followed by one IDLE cycle before the next grant.
//   wclk, wrst : write clock, asynchronous active-high reset
//   req_valid  : per-producer beat valid
//   req_last   : per-producer last beat of burst
//   req_data   : per-producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : per-producer beat accept (only the granted producer)
//   full       : FIFO full flag, consumed combinationally
//   wen        : FIFO write enable
//   data_in    : FIFO write data (granted producer's data, 0 when idle)
//   grant_id   : current or most recently granted producer
//   busy       : a grant is active
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned IW = bits_for(NUM_REQ);
  localparam int unsigned BW = bits_for(MAX_BURST + 1);
  localparam int unsigned TW = bits_for(IDLE_TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_FINAL = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] LAST_INIT  = IW'(NUM_REQ - 1);

  arb_state_e                state;
  logic [IW-1:0]             last_grant;
  logic [BW-1:0]             beat_cnt;
  logic [TW-1:0]             to_cnt;
  logic [TW-1:0]             to_next;

  logic                      any_req;
  logic [IW-1:0]             pick;

  logic                      in_burst;
  logic                      sel_valid;
  logic                      sel_last;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      xfer;
  logic                      end_by_beat;
  logic                      end_by_idle;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick       (pick)
  );

  // Granted producer's lanes.
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_burst = (state == BURST);
  assign busy     = in_burst;

  always_comb begin
    req_ready = '0;
    if (in_burst) begin
      req_ready[grant_id] = ~full;
    end
  end

  // full gates the write in the same cycle, so wen can never rise while full.
  assign xfer    = in_burst & sel_valid & ~full;
  assign wen     = xfer;
  assign data_in = in_burst ? sel_data : '0;

  assign end_by_beat = xfer & (sel_last | (beat_cnt == BEAT_FINAL));

  // Only cycles with valid low advance the idle count; a full stall with
  // valid high leaves it untouched.
  assign to_next     = to_cnt + 1'b1;
  assign end_by_idle = in_burst & ~sel_valid & (to_next == TO_LIMIT);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
      beat_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= BURST;
            grant_id <= pick;
            beat_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        BURST: begin
          if (xfer) begin
            to_cnt <= '0;
            if (end_by_beat) begin
              state      <= IDLE;
              last_grant <= grant_id;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (!sel_valid) begin
            if (end_by_idle) begin
              state      <= IDLE;
              last_grant <= grant_id;
              beat_cnt   <= '0;
              to_cnt     <= '0;
            end else begin
              to_cnt <= to_next;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (DATA_WIDTH 8, NUM_REQ 4,
// MAX_BURST 4, IDLE_TIMEOUT 8). A transaction-level model of the grant
// rules predicts every output each cycle; literal checks on the logged
// grant order, written data and busy run lengths pin the model.
module tb_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IT = 8;

  logic           wclk = 1'b0;
  logic           wrst = 1'b0;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           full;
  logic           wen;
  logic [DW-1:0]  data_in;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_write_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_REQ      (NR),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wen       (wen),
    .data_in   (data_in),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Model state: owner -1 means no grant.
  int m_owner, m_beats, m_quiet, m_prev, m_shown;

  // Producer beat queues.
  logic [7:0] p_data [NR][32];
  logic       p_last [NR][32];
  int         p_head [NR];
  int         p_tail [NR];
  logic       xfer_seen [NR];

  // Observation logs.
  int grant_log[$];
  int data_log[$];
  int run_log[$];
  int gap_log[$];
  int busy_run, idle_run;
  logic prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_quiet = 0; m_prev = NR - 1; m_shown = 0;
  endtask

  task automatic model_step();
    if (wrst) begin
      model_reset();
    end else if (m_owner < 0) begin
      bit got;
      got = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_prev + k) % NR;
        if (!got && req_valid[c]) begin
          got = 1'b1; m_owner = c; m_shown = c;
        end
      end
      m_beats = 0; m_quiet = 0;
    end else if (req_valid[m_owner] && !full) begin
      m_beats++; m_quiet = 0;
      if (req_last[m_owner] || m_beats == MB) begin
        m_prev = m_owner; m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_quiet++;
      if (m_quiet == IT) begin
        m_prev = m_owner; m_owner = -1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [NR-1:0] e_ready;
    logic          e_wen;
    logic [DW-1:0] e_data;
    e_ready = '0; e_wen = 1'b0; e_data = '0;
    if (m_owner >= 0) begin
      e_ready[m_owner] = ~full;
      e_wen  = req_valid[m_owner] & ~full;
      e_data = req_data[m_owner*DW +: DW];
    end
    chk("busy", busy, (m_owner >= 0));
    chk("req_ready", req_ready, e_ready);
    chk("wen", wen, e_wen);
    chk("data_in", data_in, e_data);
    chk("grant_id", grant_id, m_shown);
    chk("wen_while_full", wen & full, 0);
    if (wrst) begin
      prev_busy = 1'b0; idle_run = 0; busy_run = 0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          grant_log.push_back(int'(grant_id));
          gap_log.push_back(idle_run);
          busy_run = 0;
        end
        busy_run++; idle_run = 0;
      end else begin
        if (prev_busy) run_log.push_back(busy_run);
        idle_run++;
      end
      prev_busy = busy;
      if (wen) data_log.push_back(int'(data_in));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (p_head[i] < p_tail[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = p_last[i][p_head[i]];
        req_data[i*DW +: DW] = p_data[i][p_head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    if (p_tail[i] < 32) begin
      p_data[i][p_tail[i]] = d;
      p_last[i][p_tail[i]] = l;
      p_tail[i]++;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      p_head[i] = 0; p_tail[i] = 0; xfer_seen[i] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); data_log.delete(); run_log.delete(); gap_log.delete();
  endtask

  // One clock: compare at negedge, model update at posedge, producers
  // advance 2 time units after the edge.
  task automatic cycle();
    @(negedge wclk);
    compare_outputs();
    for (int i = 0; i < NR; i++) xfer_seen[i] = req_valid[i] & req_ready[i];
    @(posedge wclk);
    model_step();
    #2;
    for (int i = 0; i < NR; i++) if (xfer_seen[i]) p_head[i]++;
    drive();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    model_reset();
    clear_queues();
    full = 1'b0;
    drive();
    cycle();
    cycle();
    wrst = 1'b0;
    prev_busy = 1'b0; idle_run = 0; busy_run = 0;
  endtask

  initial begin
    int n;
    req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    clear_queues();
    model_reset();
    prev_busy = 1'b0; idle_run = 0; busy_run = 0;
    wrst = 1'b1;
    @(posedge wclk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", data_in, 0);
    chk("rst_gid", grant_id, 0);

    // T1: single 3-beat burst from producer 2.
    do_reset();
    clear_logs();
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
    drive();
    repeat (8) cycle();
    chk("t1_nwrites", data_log.size(), 3);
    chk("t1_d0", qat(data_log, 0), 32'hA0);
    chk("t1_d1", qat(data_log, 1), 32'hA1);
    chk("t1_d2", qat(data_log, 2), 32'hA2);
    chk("t1_grant", qat(grant_log, 0), 2);
    chk("t1_ngrants", grant_log.size(), 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_gid_hold", grant_id, 2);

    // T2: all producers saturated, bursts truncated at MAX_BURST.
    do_reset();
    clear_logs();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) push(i, 8'((i << 4) | k), 1'b0);
    drive();
    repeat (45) cycle();
    for (int g = 0; g < 5; g++) chk("t2_order", qat(grant_log, g), g % NR);
    for (int g = 1; g < 8; g++) chk("t2_bubble", qat(gap_log, g), 1);
    for (int g = 0; g < 8; g++) chk("t2_runlen", qat(run_log, g), MB);
    chk("t2_nwrites", data_log.size(), 32);
    chk("t2_d4", qat(data_log, 4), 32'h10);
    chk("t2_d16", qat(data_log, 16), 32'h04);
    chk("t2_d31", qat(data_log, 31), 32'h37);

    // T3: full held high mid-burst from producer 1.
    clear_logs();
    for (int k = 0; k < 4; k++) push(1, 8'(8'hB0 + k), (k == 3));
    drive();
    n = 0;
    while (data_log.size() < 2 && n < 20) begin cycle(); n++; end
    chk("t3_two_beats", data_log.size(), 2);
    full = 1'b1;
    repeat (20) cycle();
    chk("t3_stall_nowrite", data_log.size(), 2);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_ready", req_ready, 0);
    full = 1'b0;
    repeat (8) cycle();
    chk("t3_nwrites", data_log.size(), 4);
    chk("t3_d3", qat(data_log, 3), 32'hB3);
    chk("t3_ngrants", grant_log.size(), 1);
    chk("t3_grant", qat(grant_log, 0), 1);

    // T4: producer 3 goes quiet after one beat; timeout hands over to 0.
    clear_logs();
    push(3, 8'hC0, 1'b0);
    push(0, 8'hD0, 1'b1);
    drive();
    repeat (16) cycle();
    chk("t4_g0", qat(grant_log, 0), 3);
    chk("t4_g1", qat(grant_log, 1), 0);
    chk("t4_timeout_run", qat(run_log, 0), 1 + IT);
    chk("t4_d0", qat(data_log, 0), 32'hC0);
    chk("t4_d1", qat(data_log, 1), 32'hD0);

    // T5: asynchronous reset mid-burst from producer 0.
    clear_logs();
    for (int k = 0; k < 4; k++) push(0, 8'(8'hE0 + k), (k == 3));
    drive();
    n = 0;
    while (data_log.size() < 1 && n < 20) begin cycle(); n++; end
    chk("t5_first_beat", data_log.size(), 1);
    @(negedge wclk);
    #3;
    wrst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_wen", wen, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_data", data_in, 0);
    push(1, 8'hF0, 1'b1);
    drive();
    @(posedge wclk);
    model_step();
    #2;
    wrst = 1'b0;
    prev_busy = 1'b0; idle_run = 0; busy_run = 0;
    clear_logs();
    repeat (14) cycle();
    chk("t5_g0", qat(grant_log, 0), 0);
    chk("t5_g1", qat(grant_log, 1), 1);
    chk("t5_d0", qat(data_log, 0), 32'hE1);
    chk("t5_d2", qat(data_log, 2), 32'hE3);
    chk("t5_d3", qat(data_log, 3), 32'hF0);

    // T6: single producer, one-beat bursts back to back, then under full.
    clear_logs();
    for (int k = 0; k < 6; k++) push(1, 8'(8'h50 + k), 1'b1);
    drive();
    repeat (14) cycle();
    chk("t6_ngrants", grant_log.size(), 6);
    for (int g = 0; g < 6; g++) chk("t6_gid", qat(grant_log, g), 1);
    for (int g = 0; g < 6; g++) chk("t6_data", qat(data_log, g), 32'h50 + g);
    for (int g = 0; g < 5; g++) chk("t6_run", qat(run_log, g), 1);
    for (int g = 1; g < 6; g++) chk("t6_gap", qat(gap_log, g), 1);
    push(1, 8'h60, 1'b1); push(1, 8'h61, 1'b1);
    drive();
    full = 1'b1;
    repeat (6) cycle();
    chk("t6_full_nowrite", data_log.size(), 6);
    chk("t6_full_busy", busy, 1);
    full = 1'b0;
    repeat (6) cycle();
    chk("t6_after_full", data_log.size(), 8);
    chk("t6_d7", qat(data_log, 7), 32'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
